// File: rtl/wt_mem_pkg.sv
// Shared definitions for the layer weight/bias memory arbiters: op encoding,
// arbiter state and the default port widths of each layer memory.
package wt_mem_pkg;

    localparam logic OP_RD = 1'b0;
    localparam logic OP_WR = 1'b1;

    typedef enum logic [0:0] {
        ARB_UNLOCKED = 1'b0,
        ARB_LOCKED   = 1'b1
    } arb_state_t;

    localparam int CONV1_BANK_BW = 3;
    localparam int CONV1_ADDR_BW = 3;
    localparam int CONV1_DATA_BW = 104;
    localparam int CONV2_BANK_BW = 3;
    localparam int CONV2_ADDR_BW = 4;
    localparam int CONV2_DATA_BW = 64;
    localparam int FC_BANK_BW    = 2;
    localparam int FC_ADDR_BW    = 8;
    localparam int FC_DATA_BW    = 32;

    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wt_mem_arbiter_rr_pick.sv
// Combinational round-robin picker: one-hot grant to the first set request at
// or above ptr, wrapping around.
module rr_pick
    import wt_mem_pkg::*;
#(
    parameter int N     = 2,
    parameter int PTR_W = ptr_w(N)
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt
);

    logic [PTR_W-1:0] idx;

    // Walk from the lowest priority offset down so the nearest request wins last.
    always_comb begin
        gnt = '0;
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = PTR_W'((int'(ptr) + i) % N);
            if (req[idx]) begin
                gnt      = '0;
                gnt[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wt_mem_arbiter.sv
// Round-robin arbiter with bus lock in front of one layer weight memory.
// Optional grant/wait counters: define WT_MEM_ARB_PERF_CNT_EN.
module wt_mem_arbiter
    import wt_mem_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int BANK_BW    = 3,
    parameter int ADDR_BW    = 4,
    parameter int DATA_BW    = 64,
    parameter int RD_LATENCY = 1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [NUM_REQ-1:0]         req_we_i,
    input  logic [NUM_REQ-1:0]         req_lock_i,
    input  logic [NUM_REQ*BANK_BW-1:0] req_bank_i,
    input  logic [NUM_REQ*ADDR_BW-1:0] req_addr_i,
    input  logic [NUM_REQ*DATA_BW-1:0] req_wdata_i,
    output logic [NUM_REQ-1:0]         gnt_o,
    output logic [NUM_REQ-1:0]         rvalid_o,
    output logic [DATA_BW-1:0]         rdata_o,
    output logic                       mem_rd_en_o,
    output logic                       mem_wr_en_o,
    output logic [BANK_BW-1:0]         mem_bank_o,
    output logic [ADDR_BW-1:0]         mem_addr_o,
    output logic [DATA_BW-1:0]         mem_wr_data_o,
`ifdef WT_MEM_ARB_PERF_CNT_EN
    output logic [NUM_REQ*16-1:0]      perf_gnt_cnt_o,
    output logic [NUM_REQ*16-1:0]      perf_wait_cnt_o,
`endif
    input  logic [DATA_BW-1:0]         mem_rd_data_i
);

    localparam int PTR_W = ptr_w(NUM_REQ);

    arb_state_t                        state;
    logic [PTR_W-1:0]                  owner, rr_ptr, gnt_idx, nxt_ptr;
    logic [NUM_REQ-1:0]                elig, gnt;
    logic                              gnt_any, sel_we, sel_lock;
    logic [RD_LATENCY:0]               vld_pipe;
    logic [RD_LATENCY:0][PTR_W-1:0]    tag_pipe;

    // While locked only the owner is eligible; nothing is granted in reset.
    always_comb begin
        elig = req_i;
        if (state == ARB_LOCKED) begin
            elig        = '0;
            elig[owner] = req_i[owner];
        end
        if (rst_i) elig = '0;
    end

    rr_pick #(.N(NUM_REQ), .PTR_W(PTR_W)) u_pick (
        .req (elig),
        .ptr (rr_ptr),
        .gnt (gnt)
    );

    always_comb begin
        gnt_idx = '0;
        for (int r = 0; r < NUM_REQ; r++)
            if (gnt[r]) gnt_idx = PTR_W'(r);
    end

    assign gnt_o    = gnt;
    assign gnt_any  = |gnt;
    assign sel_we   = req_we_i[gnt_idx];
    assign sel_lock = req_lock_i[gnt_idx];
    assign nxt_ptr  = (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state         <= ARB_UNLOCKED;
            owner         <= '0;
            rr_ptr        <= '0;
            mem_wr_en_o   <= 1'b0;
            mem_bank_o    <= '0;
            mem_addr_o    <= '0;
            mem_wr_data_o <= '0;
            vld_pipe      <= '0;
            tag_pipe      <= '0;
        end else begin
            // Stage 0 doubles as the read strobe; the tag rides along to the data.
            vld_pipe    <= {vld_pipe[RD_LATENCY-1:0], gnt_any & (sel_we == OP_RD)};
            tag_pipe    <= {tag_pipe[RD_LATENCY-1:0], gnt_idx};
            mem_wr_en_o <= gnt_any & (sel_we == OP_WR);
            if (gnt_any) begin
                rr_ptr        <= nxt_ptr;
                owner         <= gnt_idx;
                state         <= sel_lock ? ARB_LOCKED : ARB_UNLOCKED;
                mem_bank_o    <= req_bank_i[int'(gnt_idx)*BANK_BW +: BANK_BW];
                mem_addr_o    <= req_addr_i[int'(gnt_idx)*ADDR_BW +: ADDR_BW];
                mem_wr_data_o <= req_wdata_i[int'(gnt_idx)*DATA_BW +: DATA_BW];
            end
        end
    end

    assign mem_rd_en_o = vld_pipe[0];
    assign rdata_o     = mem_rd_data_i;

    always_comb begin
        rvalid_o = '0;
        if (vld_pipe[RD_LATENCY]) rvalid_o[tag_pipe[RD_LATENCY]] = 1'b1;
    end

`ifdef WT_MEM_ARB_PERF_CNT_EN
    for (genvar r = 0; r < NUM_REQ; r++) begin : g_perf
        logic [15:0] gnt_cnt, wait_cnt;
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                gnt_cnt  <= '0;
                wait_cnt <= '0;
            end else begin
                if (gnt[r] && gnt_cnt != 16'hFFFF)
                    gnt_cnt <= gnt_cnt + 16'd1;
                if (req_i[r] && !gnt[r] && wait_cnt != 16'hFFFF)
                    wait_cnt <= wait_cnt + 16'd1;
            end
        end
        assign perf_gnt_cnt_o[r*16 +: 16]  = gnt_cnt;
        assign perf_wait_cnt_o[r*16 +: 16] = wait_cnt;
    end
`endif

endmodule

// File: tb/tb_wt_mem_arbiter.sv
// Directed bench for wt_mem_arbiter: grant order, lock, command and read return
// through a scoreboard, on a latency-1 and a latency-3 instance.
module tb_wt_mem_arbiter;

    localparam int NR = 2;
    localparam int BB = 3;
    localparam int AB = 4;
    localparam int DB = 64;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [NR-1:0]    req, we, lock;
    logic [NR*BB-1:0] bank;
    logic [NR*AB-1:0] addr;
    logic [NR*DB-1:0] wdata;

    logic [NR-1:0] gnt1, rvalid1, gnt3, rvalid3;
    logic [DB-1:0] rdata1, wdata1o, rdin1, rdata3, wdata3o, rdin3;
    logic          rd_en1, wr_en1, rd_en3, wr_en3;
    logic [BB-1:0] bank1o, bank3o;
    logic [AB-1:0] addr1o, addr3o;
`ifdef WT_MEM_ARB_PERF_CNT_EN
    logic [NR*16-1:0] pg1, pw1, pg3, pw3;
`endif

    wt_mem_arbiter #(.NUM_REQ(NR), .BANK_BW(BB), .ADDR_BW(AB), .DATA_BW(DB), .RD_LATENCY(1)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .req_we_i(we), .req_lock_i(lock),
        .req_bank_i(bank), .req_addr_i(addr), .req_wdata_i(wdata),
        .gnt_o(gnt1), .rvalid_o(rvalid1), .rdata_o(rdata1),
        .mem_rd_en_o(rd_en1), .mem_wr_en_o(wr_en1), .mem_bank_o(bank1o),
        .mem_addr_o(addr1o), .mem_wr_data_o(wdata1o),
`ifdef WT_MEM_ARB_PERF_CNT_EN
        .perf_gnt_cnt_o(pg1), .perf_wait_cnt_o(pw1),
`endif
        .mem_rd_data_i(rdin1)
    );

    wt_mem_arbiter #(.NUM_REQ(NR), .BANK_BW(BB), .ADDR_BW(AB), .DATA_BW(DB), .RD_LATENCY(3)) dut3 (
        .clk_i(clk), .rst_i(rst), .req_i(req), .req_we_i(we), .req_lock_i(lock),
        .req_bank_i(bank), .req_addr_i(addr), .req_wdata_i(wdata),
        .gnt_o(gnt3), .rvalid_o(rvalid3), .rdata_o(rdata3),
        .mem_rd_en_o(rd_en3), .mem_wr_en_o(wr_en3), .mem_bank_o(bank3o),
        .mem_addr_o(addr3o), .mem_wr_data_o(wdata3o),
`ifdef WT_MEM_ARB_PERF_CNT_EN
        .perf_gnt_cnt_o(pg3), .perf_wait_cnt_o(pw3),
`endif
        .mem_rd_data_i(rdin3)
    );

    function automatic logic [DB-1:0] init_val(input logic [BB-1:0] b, input logic [AB-1:0] a);
        return 64'hC0DE_0000_0000_0000 | {56'd0, 1'b0, b, a};
    endfunction

    // Memory model: writes from dut's port, one read pipeline per instance.
    logic [DB-1:0] mem [8][16];
    logic [DB-1:0] rd_pipe1;
    logic [DB-1:0] rd_pipe3 [3];
    always @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < 8; b++)
                for (int a = 0; a < 16; a++)
                    mem[b][a] <= init_val(3'(b), 4'(a));
        end else if (wr_en1) begin
            mem[bank1o][addr1o] <= wdata1o;
        end
        if (rd_en1) rd_pipe1 <= mem[bank1o][addr1o];
        if (rd_en3) rd_pipe3[0] <= mem[bank3o][addr3o];
        rd_pipe3[1] <= rd_pipe3[0];
        rd_pipe3[2] <= rd_pipe3[1];
    end
    assign rdin1 = rd_pipe1;
    assign rdin3 = rd_pipe3[2];

    typedef struct {
        logic [NR-1:0] oh;
        logic [DB-1:0] data;
        int            due;
    } rd_exp_t;

    rd_exp_t       q1[$], q3[$];
    logic [DB-1:0] shadow [8][16];
    int            checks = 0, failures = 0, cyc_n = 0;
    logic          exp_rd, exp_wr;
    logic [BB-1:0] exp_bank;
    logic [AB-1:0] exp_addr;
    logic [DB-1:0] exp_wdata;
    int            n_gnt [NR];
    int            n_wait [NR];

    task automatic chk(input string tag, input logic [DB-1:0] obs, input logic [DB-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int r, input logic on, input logic w, input logic lk,
                         input logic [BB-1:0] b, input logic [AB-1:0] a, input logic [DB-1:0] d);
        req[r]              = on;
        we[r]               = w;
        lock[r]             = lk;
        bank[r*BB +: BB]    = b;
        addr[r*AB +: AB]    = a;
        wdata[r*DB +: DB]   = d;
    endtask

    task automatic clear();
        req  = '0;
        we   = '0;
        lock = '0;
    endtask

    // One cycle: check outputs at the falling edge, then update the model.
    task automatic cyc(input logic [NR-1:0] exp_gnt);
        int            r;
        logic [BB-1:0] b;
        logic [AB-1:0] a;
        @(negedge clk);
        if (rst) begin
            exp_rd = 1'b0; exp_wr = 1'b0;
            exp_bank = '0; exp_addr = '0; exp_wdata = '0;
            q1.delete();
            q3.delete();
            for (int i = 0; i < NR; i++) begin n_gnt[i] = 0; n_wait[i] = 0; end
            for (int bi = 0; bi < 8; bi++)
                for (int ai = 0; ai < 16; ai++)
                    shadow[bi][ai] = init_val(3'(bi), 4'(ai));
        end
        chk("gnt", 64'(gnt1), 64'(exp_gnt));
        chk("gnt_l3", 64'(gnt3), 64'(exp_gnt));
        chk("mem_rd_en", 64'(rd_en1), 64'(exp_rd));
        chk("mem_wr_en", 64'(wr_en1), 64'(exp_wr));
        chk("mem_bank", 64'(bank1o), 64'(exp_bank));
        chk("mem_addr", 64'(addr1o), 64'(exp_addr));
        chk("mem_wr_data", wdata1o, exp_wdata);
        if (q1.size() > 0 && q1[0].due == cyc_n) begin
            chk("rvalid_l1", 64'(rvalid1), 64'(q1[0].oh));
            chk("rdata_l1", rdata1, q1[0].data);
            void'(q1.pop_front());
        end else begin
            chk("rvalid_l1_idle", 64'(rvalid1), 64'd0);
        end
        if (q3.size() > 0 && q3[0].due == cyc_n) begin
            chk("rvalid_l3", 64'(rvalid3), 64'(q3[0].oh));
            chk("rdata_l3", rdata3, q3[0].data);
            void'(q3.pop_front());
        end else begin
            chk("rvalid_l3_idle", 64'(rvalid3), 64'd0);
        end
        exp_rd = 1'b0;
        exp_wr = 1'b0;
        if (!rst) begin
            for (int i = 0; i < NR; i++)
                if (exp_gnt[i]) n_gnt[i]++;
                else if (req[i]) n_wait[i]++;
        end
        if (!rst && exp_gnt != '0) begin
            r = exp_gnt[1] ? 1 : 0;
            b = bank[r*BB +: BB];
            a = addr[r*AB +: AB];
            exp_bank  = b;
            exp_addr  = a;
            exp_wdata = wdata[r*DB +: DB];
            if (we[r]) begin
                exp_wr = 1'b1;
                shadow[b][a] = wdata[r*DB +: DB];
            end else begin
                exp_rd = 1'b1;
                q1.push_back('{exp_gnt, shadow[b][a], cyc_n + 2});
                q3.push_back('{exp_gnt, shadow[b][a], cyc_n + 4});
            end
        end
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    initial begin
        rst = 1'b1;
        req = '0; we = '0; lock = '0; bank = '0; addr = '0; wdata = '0;

        // Reset with both requesting, then strict alternation from requester 0
        drive(0, 1, 0, 0, 3'd1, 4'd3, '0);
        drive(1, 1, 0, 0, 3'd0, 4'd7, '0);
        cyc(2'b00);
        cyc(2'b00);
        rst = 1'b0;
        cyc(2'b01);
        cyc(2'b10);
        cyc(2'b01);
        cyc(2'b10);
        clear();
        repeat (2) cyc(2'b00);

        // Single read of freshly written data; owner write then read back-to-back
        drive(0, 1, 1, 0, 3'd2, 4'h5, 64'hDEAD_BEEF_0123_4567);
        cyc(2'b01);
        clear();
        drive(1, 1, 0, 0, 3'd2, 4'h5, '0);
        cyc(2'b10);
        clear();
        drive(0, 1, 1, 0, 3'd3, 4'h9, 64'h0BAD_F00D_5555_AAAA);
        cyc(2'b01);
        drive(0, 1, 0, 0, 3'd3, 4'h9, '0);
        cyc(2'b01);
        clear();
        repeat (3) cyc(2'b00);

        // Locked three-write burst with an idle owner cycle; r1 waits
        drive(0, 1, 1, 1, 3'd1, 4'd0, 64'h1);
        cyc(2'b01);
        drive(0, 1, 1, 1, 3'd1, 4'd1, 64'h2);
        drive(1, 1, 0, 0, 3'd1, 4'd1, '0);
        cyc(2'b01);
        drive(0, 0, 0, 0, 3'd0, 4'd0, '0);
        cyc(2'b00);
        drive(0, 1, 1, 0, 3'd1, 4'd2, 64'h3);
        cyc(2'b01);
        drive(0, 0, 0, 0, 3'd0, 4'd0, '0);
        cyc(2'b10);
        clear();
        cyc(2'b00);

        // Back-to-back alternating reads, several outstanding on the latency-3 port
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 0, 0, 3'd1, AB'(i), '0);
            drive(1, 1, 0, 0, 3'd0, AB'(i + 8), '0);
            cyc((i % 2 == 0) ? 2'b01 : 2'b10);
        end
        clear();
        repeat (5) cyc(2'b00);

        // Reset one cycle after a read grant: pointer returns to 0, read discarded
        drive(0, 1, 0, 0, 3'd2, 4'h5, '0);
        cyc(2'b01);
        clear();
        rst = 1'b1;
        cyc(2'b00);
        rst = 1'b0;
        drive(0, 1, 0, 0, 3'd1, 4'd3, '0);
        drive(1, 1, 0, 0, 3'd0, 4'd7, '0);
        cyc(2'b01);
        clear();
        repeat (5) cyc(2'b00);

        // Reset while r1 holds the lock: lock released afterwards
        drive(1, 1, 0, 1, 3'd2, 4'h5, '0);
        cyc(2'b10);
        clear();
        rst = 1'b1;
        cyc(2'b00);
        rst = 1'b0;
        drive(0, 1, 0, 0, 3'd1, 4'd3, '0);
        drive(1, 1, 0, 0, 3'd0, 4'd7, '0);
        cyc(2'b01);
        clear();
        repeat (5) cyc(2'b00);

`ifdef WT_MEM_ARB_PERF_CNT_EN
        for (int i = 0; i < NR; i++) begin
            chk("perf_gnt", 64'(pg1[i*16 +: 16]), 64'(n_gnt[i]));
            chk("perf_wait", 64'(pw1[i*16 +: 16]), 64'(n_wait[i]));
            chk("perf_gnt_l3", 64'(pg3[i*16 +: 16]), 64'(n_gnt[i]));
        end
`endif
        chk("sb_empty_l1", 64'(q1.size()), 64'd0);
        chk("sb_empty_l3", 64'(q3.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wt_mem_arbiter.md
Name: wt_mem_arbiter

Overview:
- Shares one weight/bias memory configuration port (the bank/addr/wr_data/rd_en/wr_en/rd_data port of the conv1, conv2 or fc memories) among NUM_REQ requesters, e.g. the wishbone cfg block and a boot-time weight loader.
- Arbitration is round-robin with an optional bus lock for multi-beat sequences.
- Issues registered memory commands and routes read data back to the requester that issued each read.
- One instance sits in front of each layer memory.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- BANK_BW, 3, bank select width.
- ADDR_BW, 4, word address width.
- DATA_BW, 64, data vector width.
- RD_LATENCY, 1, cycles from mem_rd_en_o to valid mem_rd_data_i (1..3).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- req_i  in  NUM_REQ  per-requester request; held until granted.
- req_we_i  in  NUM_REQ  1=write, 0=read.
- req_lock_i  in  NUM_REQ  keep grant after this transaction.
- req_bank_i  in  NUM_REQ*BANK_BW  flattened bank, requester r at [r*BANK_BW +: BANK_BW].
- req_addr_i  in  NUM_REQ*ADDR_BW  flattened address.
- req_wdata_i  in  NUM_REQ*DATA_BW  flattened write data.
- gnt_o  out  NUM_REQ  one-hot accept, combinational, same cycle as accepted req.
- rvalid_o  out  NUM_REQ  one-hot read-data-valid pulse.
- rdata_o  out  DATA_BW  read data, broadcast to all requesters.
- mem_rd_en_o  out  1  registered read strobe.
- mem_wr_en_o  out  1  registered write strobe.
- mem_bank_o  out  BANK_BW  registered bank.
- mem_addr_o  out  ADDR_BW  registered address.
- mem_wr_data_o  out  DATA_BW  registered write data.
- mem_rd_data_i  in  DATA_BW  memory read data.

Behaviour:
- Reset: gnt_o=0, rvalid_o=0, all mem_* outputs=0, rr pointer=0 (requester 0 highest priority first), lock cleared, read-tag pipeline cleared.
- FSM:
  - UNLOCKED: at most one grant per cycle, to the first requester with req_i=1 searching from rr_ptr upward with wrap.
  - LOCKED(owner): only the owner can be granted; other requests are ignored and wait.
- Transitions:
  - Grant with req_lock_i=1: go to LOCKED(r).
  - Granted owner transaction with req_lock_i=0 in LOCKED: return to UNLOCKED.
  - The lock persists while the owner's req_i is low.
- Pointer: on any grant to r, rr_ptr <= (r+1) mod NUM_REQ. The pointer does not move while no grant is made.
- Command: grant at cycle t gives the mem_* outputs at t+1 for exactly one cycle.
  - mem_wr_en_o = req_we_i, mem_rd_en_o = !req_we_i.
  - bank/addr/data are captured at t and held until the next grant.
  - A back-to-back grant every cycle gives full throughput.
- Read return: the owner id travels a RD_LATENCY-deep tag pipeline.
  - rvalid_o[owner]=1 at cycle t+1+RD_LATENCY.
  - rdata_o = mem_rd_data_i, passed through combinationally.
  - Multiple outstanding reads return in order.
  - rvalid_o=0 for writes.
- Boundary conditions:
  - All requesters active simultaneously: strict rotation, no starvation.
  - Only one requester active: it is granted every cycle.
  - req_i deasserted before grant: no transaction. Requesters must not drop req_i before grant; this is not checked.
  - req_i to requester index >= NUM_REQ: not possible.
  - Reset mid-read: pending rvalid pulses are discarded and the lock is released.
  - Owner write then read to the same address on back-to-back cycles: the read returns the new data. This is guaranteed by command order; the memory is write-first-cycle.

Optional Feature:
- Macro: WT_MEM_ARB_PERF_CNT_EN.
- When defined: adds output perf_gnt_cnt_o (NUM_REQ*16), a per-requester saturating grant counter, reset to 0 by rst_i and saturating at 16'hFFFF.
- Also adds perf_wait_cnt_o (NUM_REQ*16), counting cycles with req_i=1 and gnt_o=0, saturating.
- When undefined: neither port nor counter logic exists; behaviour is otherwise identical.

Decomposition:
- Shared package wt_mem_pkg:
  - op encoding constants (OP_RD=0, OP_WR=1).
  - arbiter state enum (ARB_UNLOCKED, ARB_LOCKED).
  - default BANK_BW/ADDR_BW/DATA_BW per layer (conv1 3/3/104, conv2 3/4/64, fc 2/8/32).
- One sub-module: rr_pick, a combinational round-robin priority picker (req vector, pointer -> one-hot grant). It is reused by other arbiters.

Test Plan:
- Reset: with req_i=2'b11 during reset, no gnt_o and mem_* all zero. After release, requester 0 is granted first, then requester 1, alternating 0,1,0,1.
- Single read: r1 reads bank 2, addr 4'h5 at t. Then mem_rd_en_o=1, mem_bank_o=2, mem_addr_o=5 at t+1. Memory returns 64'hDEAD_BEEF_0123_4567, giving rvalid_o=2'b10 and rdata_o equal to it at t+2 (RD_LATENCY=1).
- Lock: r0 issues 3 writes with lock=1,1,0 while r1 requests continuously. r1 is first granted only in the cycle after r0's third grant. r0 idles one cycle mid-sequence without losing the lock.
- Pipelined reads: r0 and r1 alternate reads every cycle with RD_LATENCY=3. rvalid_o pattern is 01,10,01,10, delayed by 4 cycles from the grants, each with the matching data.
- Reset mid-operation: rst_i asserted one cycle after a read grant. No rvalid_o appears, the lock is cleared and rr_ptr=0 after release.
- WT_MEM_ARB_PERF_CNT_EN: 10 grants to r0 with r1 waiting 5 cycles give perf_gnt_cnt_o[0]=10 and perf_wait_cnt_o[1]=5. A counter forced to 16'hFFFF stays at 16'hFFFF.
